piso_shift_tx: RTL
==================

Name: piso_shift_tx

Overview:
Parallel-in, serial-out shift transmitter. It is the sending end of the serial-in right-shift receiver.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Serialises the word onto one data line, one bit per bit-period, with a qualifying valid strobe.
- Pulses done when the frame is complete.
- Default bit order is LSB-first. After WIDTH shifts, a right-shift receiver whose new bit enters at the MSB holds the original word.

Parameters:
WIDTH, 4, data word width in bits (>=1)
CLKS_PER_BIT, 1, clock cycles each serial bit is held (>=1)
MSB_FIRST, 0, 0 = transmit din[0] first; 1 = transmit din[WIDTH-1] first

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk edge)
din  input  WIDTH  parallel word, sampled only on load acceptance
load_valid  input  1  producer requests load of din
load_ready  output  1  block can accept a word (high only in IDLE)
sout  output  1  serial data bit
sout_valid  output  1  high while sout carries a frame bit
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse after the final bit period

Behaviour:
- Reset (rst=0 at a rising edge), takes priority over everything:
  - state=IDLE; shift register, bit counter and period counter cleared.
  - sout=0, sout_valid=0, busy=0, done=0.
  - load_ready=1 from the first post-reset cycle while rst=0.
  - Reset during SHIFT aborts the frame immediately: no done pulse, partial frame is discarded.
- All outputs are registered, except load_ready = (state==IDLE), which is combinational from state.
- State machine: IDLE, SHIFT.
  - IDLE: sout=0, sout_valid=0, busy=0.
    - Accept = load_valid && load_ready at a rising edge.
    - On accept: latch din into the shift register, bit_cnt=0, period_cnt=0, go to SHIFT.
  - SHIFT: busy=1, sout_valid=1, load_ready=0.
    - sout = shreg[0] (LSB-first) or shreg[WIDTH-1] (MSB_FIRST=1).
    - period_cnt counts 0..CLKS_PER_BIT-1. On the terminal count, shift the register by one (zero fill), increment bit_cnt, reset period_cnt.
    - When bit_cnt==WIDTH-1 and period_cnt is at terminal count, the next edge goes to IDLE with done=1, sout_valid=0, sout=0.
- Timing, with the accept at edge E0:
  - Bit k is presented on sout during cycles E0+k*CLKS_PER_BIT+1 .. E0+(k+1)*CLKS_PER_BIT.
  - done is high for exactly one cycle, starting at edge E0+WIDTH*CLKS_PER_BIT.
- Back-to-back frames:
  - load_ready is high during the done cycle, so a load accepted then starts the next frame on the following edge.
  - Minimum gap between frames is one idle cycle (sout_valid=0).
- load_valid while busy is ignored and has no effect. din changes after acceptance do not affect the frame in flight.
- With CLKS_PER_BIT=1 the period counter is degenerate: each bit is held one cycle.
- Width rules:
  - bit_cnt is $clog2(WIDTH) bits, minimum 1.
  - period_cnt is $clog2(CLKS_PER_BIT) bits, minimum 1.
  - Counters never wrap within a frame.

Test Plan:
- WIDTH=4, CLKS_PER_BIT=1, MSB_FIRST=0, reset then load din=4'b1101 -> sout=1,0,1,1 on 4 consecutive cycles with sout_valid=1; done=1 on the 5th cycle; load_ready=0 throughout.
- Loopback: the sout/sout_valid of the case above feed the right-shift receiver's serial input, with the receiver clocked only while sout_valid=1 -> receiver q=4'b1101 after 4 shifts.
- MSB_FIRST=1, din=4'b1101 -> sout=1,1,0,1; CLKS_PER_BIT=3, din=4'b0110 LSB-first -> each bit held 3 cycles (0,0,0,1,1,1,1,1,1,0,0,0); done on the 13th cycle after accept.
- Back-to-back: load 4'b1010, then hold load_valid high with din=4'b0011 -> second word accepted in the done cycle; output 0,1,0,1, then one idle cycle, then 1,1,0,0; a load_valid pulse mid-frame is ignored.
- Reset mid-frame: load 4'b1111, drive rst=0 after 2 bits -> next cycle sout=0, sout_valid=0, busy=0, no done pulse, load_ready=1; a new load of 4'b0001 then transmits 1,0,0,0 correctly.

Source files
------------

// File: rtl/piso_shift_tx_if.sv
// rtl/piso_shift_tx_if.sv - load handshake and serial output bundle for piso_shift_tx
interface piso_shift_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  // Producer side: offers words, observes the serial stream and status
  modport master (
    output din,
    output load_valid,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  busy,
    input  done
  );

  // Transmitter side
  modport slave (
    input  din,
    input  load_valid,
    output load_ready,
    output sout,
    output sout_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_shift_tx.sv
// rtl/piso_shift_tx.sv - parallel-in serial-out shift transmitter with load handshake
module piso_shift_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 0
) (
  input logic           clk,
  input logic           rst,
  piso_shift_tx_if.slave bus
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [BW-1:0]    bit_cnt;
  logic [PW-1:0]    period_cnt;
  logic             busy_q;
  logic             valid_q;
  logic             done_q;
  logic             accept;
  logic             period_last;
  logic             bit_last;

  // Ready is the only combinational output so a word can be taken in the done cycle
  assign bus.load_ready = (state == S_IDLE);
  assign accept         = bus.load_valid && (state == S_IDLE);

  assign period_last = (period_cnt == PW'(CLKS_PER_BIT - 1));
  assign bit_last    = (bit_cnt == BW'(WIDTH - 1));

  // Zero-fill shift towards the output end; after WIDTH shifts the register is empty
  always_comb begin
    shreg_next = shreg;
    if (MSB_FIRST != 0) begin
      shreg_next = shreg << 1;
    end else begin
      shreg_next = shreg >> 1;
    end
  end

  // The output end of the shift register drives sout directly; the drained
  // register guarantees sout=0 once the frame has ended
  assign bus.sout       = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign bus.sout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  // Frame sequencing: load on accept, hold each bit CLKS_PER_BIT cycles, pulse done
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      period_cnt <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg      <= bus.din;
            bit_cnt    <= '0;
            period_cnt <= '0;
            busy_q     <= 1'b1;
            valid_q    <= 1'b1;
            state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (period_last) begin
            period_cnt <= '0;
            shreg      <= shreg_next;
            if (bit_last) begin
              bit_cnt <= '0;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state   <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            period_cnt <= period_cnt + PW'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
